load_unit: RTL and testbench

Sequences one data-memory load at a time for the haze-cpu memory stage. It accepts a load from the pipeline, issues a word-aligned request on the data-memory bus and waits for read data. It then selects the addressed byte or halfword lane and zero- or sign-extends it through extender_NtoM. Finally it holds the result on a writeback handshake until the pipeline consumes it.

---
 rtl/load_unit_pkg.sv | 36 +++
 rtl/load_unit_if.sv | 41 ++++
 rtl/extender_NtoM.sv | 11 +
 rtl/load_unit_align.sv | 40 ++++
 rtl/load_unit.sv | 100 ++++++++++
 tb/tb_load_unit.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/load_unit_pkg.sv
// Shared types for the haze-cpu load/store path.
// Load sizes, load FSM states and the alignment-fault rule.
package haze_lsu_pkg;

    localparam int LANE_BITS = 2;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } load_size_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } load_state_t;

    function automatic logic load_fault(
        input load_size_t             s,
        input logic [LANE_BITS-1:0]   a
    );
        logic f;
        f = 1'b0;
        unique case (s)
            SIZE_HALF:    f = a[0];
            SIZE_WORD:    f = |a;
            SIZE_ILLEGAL: f = 1'b1;
            default:      f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// Pipeline, data-memory and writeback signals of the load unit.
// slave is the unit side, master the pipeline/memory side.
interface load_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_WIDTH   = 5
);
    logic                  i_Valid;
    logic                  o_Ready;
    logic [ADDR_WIDTH-1:0] i_Address;
    logic [1:0]            i_Size;
    logic                  i_Unsigned;
    logic [RD_WIDTH-1:0]   i_Rd;
    logic                  o_MemReq;
    logic [ADDR_WIDTH-1:0] o_MemAddr;
    logic                  i_MemGnt;
    logic                  i_MemRValid;
    logic [DATA_WIDTH-1:0] i_MemRData;
    logic                  i_MemErr;
    logic                  o_WbValid;
    logic                  i_WbReady;
    logic [DATA_WIDTH-1:0] o_WbData;
    logic [RD_WIDTH-1:0]   o_WbRd;
    logic                  o_Fault;

    modport slave (
        input  i_Valid, i_Address, i_Size, i_Unsigned, i_Rd,
        input  i_MemGnt, i_MemRValid, i_MemRData, i_MemErr,
        input  i_WbReady,
        output o_Ready, o_MemReq, o_MemAddr,
        output o_WbValid, o_WbData, o_WbRd, o_Fault
    );

    modport master (
        output i_Valid, i_Address, i_Size, i_Unsigned, i_Rd,
        output i_MemGnt, i_MemRValid, i_MemRData, i_MemErr,
        output i_WbReady,
        input  o_Ready, o_MemReq, o_MemAddr,
        input  o_WbValid, o_WbData, o_WbRd, o_Fault
    );
endinterface

// File: rtl/extender_NtoM.sv
// Widens an N-bit value to M bits by zero or sign extension.
module extender_NtoM #(
    parameter int N = 8,
    parameter int M = 32
) (
    input  logic [N-1:0] i_Data,
    input  logic         i_Signed,
    output logic [M-1:0] o_Data
);
    assign o_Data = {{(M-N){i_Signed & i_Data[N-1]}}, i_Data};
endmodule

// File: rtl/load_unit_align.sv
// Picks the addressed lane out of a read word and extends it.
module load_align
    import haze_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_RData,
    input  logic [LANE_BITS-1:0]  i_Lane,
    input  load_size_t            i_Size,
    input  logic                  i_Unsigned,
    output logic [DATA_WIDTH-1:0] o_Data
);
    logic [DATA_WIDTH-1:0] lane_w;
    logic [DATA_WIDTH-1:0] byte_ext;
    logic [DATA_WIDTH-1:0] half_ext;

    assign lane_w = i_RData >> {i_Lane, 3'b000};

    extender_NtoM #(.N(8), .M(DATA_WIDTH)) u_ext_b (
        .i_Data   (lane_w[7:0]),
        .i_Signed (~i_Unsigned),
        .o_Data   (byte_ext)
    );

    extender_NtoM #(.N(16), .M(DATA_WIDTH)) u_ext_h (
        .i_Data   (lane_w[15:0]),
        .i_Signed (~i_Unsigned),
        .o_Data   (half_ext)
    );

    always_comb begin
        o_Data = '0;
        unique case (i_Size)
            SIZE_BYTE: o_Data = byte_ext;
            SIZE_HALF: o_Data = half_ext;
            SIZE_WORD: o_Data = lane_w;
            default:   o_Data = '0;
        endcase
    end
endmodule

// File: rtl/load_unit.sv
// Single-outstanding data-memory load sequencer for the memory stage.
module load_unit
    import haze_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic       i_CLK,
    input  logic       i_RSTn,
    load_unit_if.slave bus
);
    load_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    load_size_t            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [RD_WIDTH-1:0]   rd_q, rd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] aligned;
    load_size_t            in_size;

    assign in_size = load_size_t'(bus.i_Size);

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .i_RData    (bus.i_MemRData),
        .i_Lane     (addr_q[LANE_BITS-1:0]),
        .i_Size     (size_q),
        .i_Unsigned (uns_q),
        .o_Data     (aligned)
    );

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        data_d  = data_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_Valid) begin
                    addr_d  = bus.i_Address;
                    size_d  = in_size;
                    uns_d   = bus.i_Unsigned;
                    rd_d    = bus.i_Rd;
                    data_d  = '0;
                    fault_d = load_fault(in_size,
                                         bus.i_Address[LANE_BITS-1:0]);
                    // Faulting loads never touch the bus.
                    state_d = fault_d ? RESP : REQ;
                end
            end
            REQ: begin
                if (bus.i_MemGnt) state_d = WAIT;
            end
            WAIT: begin
                if (bus.i_MemRValid) begin
                    state_d = RESP;
                    fault_d = bus.i_MemErr;
                    data_d  = bus.i_MemErr ? '0 : aligned;
                end
            end
            RESP: begin
                if (bus.i_WbReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_Ready   = (state_q == IDLE);
    assign bus.o_MemReq  = (state_q == REQ);
    assign bus.o_MemAddr = {addr_q[ADDR_WIDTH-1:LANE_BITS],
                            {LANE_BITS{1'b0}}};
    assign bus.o_WbValid = (state_q == RESP);
    assign bus.o_WbData  = data_q;
    assign bus.o_WbRd    = rd_q;
    assign bus.o_Fault   = fault_q;
endmodule

// File: tb/tb_load_unit.sv
// Directed plus randomized bench for load_unit.
module tb_load_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    load_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_WIDTH(5)) bus ();

    load_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_WIDTH(5)) dut (
        .i_CLK  (clk),
        .i_RSTn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_fault(input logic [31:0] addr,
                                      input logic [1:0] size);
        int off;
        off = int'(addr % 4);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1 && (off % 2) != 0) return 1'b1;
        if (size == 2'd2 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: byte offset shift, modulo lane width, signed wraparound.
    function automatic void model(input logic [31:0] addr,
                                  input logic [1:0] size, input logic uns,
                                  input logic [31:0] rdata, input logic err,
                                  output logic [31:0] data,
                                  output logic fault);
        longint v;
        longint w;
        w = longint'(rdata) / (longint'(1) << (8 * (addr % 4)));
        if (addr_fault(addr, size) || err) begin
            fault = 1'b1;
            data  = 32'd0;
            return;
        end
        fault = 1'b0;
        case (size)
            2'd0: begin
                v = w % 256;
                if (!uns && v >= 128) v = v - 256;
            end
            2'd1: begin
                v = w % 65536;
                if (!uns && v >= 32768) v = v - 65536;
            end
            default: v = w;
        endcase
        data = v[31:0];
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.o_Ready), 32'd1);
        chk({tag, "_memreq"}, 32'(bus.o_MemReq), 32'd0);
        chk({tag, "_memaddr"}, bus.o_MemAddr, 32'd0);
        chk({tag, "_wbvalid"}, 32'(bus.o_WbValid), 32'd0);
        chk({tag, "_wbdata"}, bus.o_WbData, 32'd0);
        chk({tag, "_wbrd"}, 32'(bus.o_WbRd), 32'd0);
        chk({tag, "_fault"}, 32'(bus.o_Fault), 32'd0);
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [4:0] rd,
                            input logic [31:0] rdata, input logic err,
                            input int gnt_dly, input int wb_dly);
        logic [31:0] ed;
        logic        ef;
        logic [31:0] wa;
        bit          af;
        model(addr, size, uns, rdata, err, ed, ef);
        af = addr_fault(addr, size);
        wa = addr & 32'hFFFF_FFFC;
        @(negedge clk);
        chk("ready_idle", 32'(bus.o_Ready), 32'd1);
        bus.i_Valid    = 1'b1;
        bus.i_Address  = addr;
        bus.i_Size     = size;
        bus.i_Unsigned = uns;
        bus.i_Rd       = rd;
        @(negedge clk);
        bus.i_Valid   = 1'b0;
        bus.i_Address = $urandom;
        bus.i_Rd      = 5'($urandom);
        if (af) begin
            chk("fault_memreq", 32'(bus.o_MemReq), 32'd0);
            chk("fault_lat1", 32'(bus.o_WbValid), 32'd1);
        end else begin
            chk("req_c1", 32'(bus.o_MemReq), 32'd1);
            chk("req_addr", bus.o_MemAddr, wa);
            chk("req_ready", 32'(bus.o_Ready), 32'd0);
            for (int i = 0; i < gnt_dly; i++) begin
                bus.i_MemRValid = 1'b1;
                bus.i_MemRData  = $urandom;
                bus.i_MemErr    = 1'($urandom);
                @(negedge clk);
                chk("req_hold", 32'(bus.o_MemReq), 32'd1);
                chk("req_addr_hold", bus.o_MemAddr, wa);
                chk("req_ready_hold", 32'(bus.o_Ready), 32'd0);
            end
            bus.i_MemRValid = 1'b0;
            bus.i_MemErr    = 1'b0;
            bus.i_MemGnt    = 1'b1;
            @(negedge clk);
            bus.i_MemGnt = 1'b0;
            chk("wait_memreq", 32'(bus.o_MemReq), 32'd0);
            chk("wait_wbvalid", 32'(bus.o_WbValid), 32'd0);
            bus.i_MemRValid = 1'b1;
            bus.i_MemRData  = rdata;
            bus.i_MemErr    = err;
            @(negedge clk);
            bus.i_MemRValid = 1'b0;
            bus.i_MemErr    = 1'b0;
            chk("resp_lat", 32'(bus.o_WbValid), 32'd1);
        end
        chk("wb_data", bus.o_WbData, ed);
        chk("wb_rd", 32'(bus.o_WbRd), 32'(rd));
        chk("wb_fault", 32'(bus.o_Fault), 32'(ef));
        bus.i_Valid   = 1'b1;
        bus.i_Size    = 2'b11;
        for (int i = 0; i < wb_dly; i++) begin
            bus.i_MemRValid = 1'b1;
            bus.i_MemRData  = $urandom;
            @(negedge clk);
            chk("hold_valid", 32'(bus.o_WbValid), 32'd1);
            chk("hold_data", bus.o_WbData, ed);
            chk("hold_rd", 32'(bus.o_WbRd), 32'(rd));
            chk("hold_fault", 32'(bus.o_Fault), 32'(ef));
            chk("hold_ready", 32'(bus.o_Ready), 32'd0);
        end
        bus.i_MemRValid = 1'b0;
        bus.i_WbReady   = 1'b1;
        @(negedge clk);
        bus.i_WbReady = 1'b0;
        bus.i_Valid   = 1'b0;
        chk("post_wbvalid", 32'(bus.o_WbValid), 32'd0);
        chk("post_ready", 32'(bus.o_Ready), 32'd1);
        chk("post_memreq", 32'(bus.o_MemReq), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.i_Valid     = 1'b0;
        bus.i_Address   = '0;
        bus.i_Size      = '0;
        bus.i_Unsigned  = 1'b0;
        bus.i_Rd        = '0;
        bus.i_MemGnt    = 1'b0;
        bus.i_MemRValid = 1'b0;
        bus.i_MemRData  = '0;
        bus.i_MemErr    = 1'b0;
        bus.i_WbReady   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst");

        run_load(32'h1003, 2'b00, 1'b0, 5'd1, 32'h80AA55CC, 1'b0, 0, 0);
        chk("lb_value", bus.o_WbData, 32'hFFFFFF80);
        run_load(32'h2002, 2'b01, 1'b1, 5'd2, 32'hBEEF1234, 1'b0, 0, 1);
        run_load(32'h2002, 2'b01, 1'b0, 5'd3, 32'hBEEF1234, 1'b0, 1, 0);
        run_load(32'h3000, 2'b10, 1'b0, 5'd4, 32'hBEEF1234, 1'b0, 0, 0);
        run_load(32'h1001, 2'b10, 1'b0, 5'd5, 32'h0, 1'b0, 0, 1);
        run_load(32'h1001, 2'b01, 1'b0, 5'd6, 32'h0, 1'b0, 0, 0);
        run_load(32'h1000, 2'b11, 1'b0, 5'd8, 32'h0, 1'b0, 0, 2);
        run_load(32'h5004, 2'b10, 1'b0, 5'd7, 32'hCAFEF00D, 1'b0, 3, 4);
        run_load(32'h4000, 2'b10, 1'b0, 5'd9, 32'h11223344, 1'b1, 0, 1);
        run_load(32'h4001, 2'b00, 1'b1, 5'd10, 32'h11223344, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [1:0]  s;
            s = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'd1) a = a & 32'hFFFF_FFFE;
                if (s == 2'd2) a = a & 32'hFFFF_FFFC;
            end
            run_load(a, s, 1'($urandom), 5'($urandom), $urandom,
                     1'($urandom_range(0, 5) == 0),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset while WAIT; the late response must be dropped.
        @(negedge clk);
        bus.i_Valid    = 1'b1;
        bus.i_Address  = 32'h6000;
        bus.i_Size     = 2'b10;
        bus.i_Unsigned = 1'b0;
        bus.i_Rd       = 5'd12;
        @(negedge clk);
        bus.i_Valid  = 1'b0;
        bus.i_MemGnt = 1'b1;
        @(negedge clk);
        bus.i_MemGnt = 1'b0;
        chk("rstw_memreq", 32'(bus.o_MemReq), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstw_async_ready", 32'(bus.o_Ready), 32'd1);
        chk("rstw_async_addr", bus.o_MemAddr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_MemRValid = 1'b1;
        bus.i_MemRData  = 32'h12345678;
        @(negedge clk);
        bus.i_MemRValid = 1'b0;
        chk_reset_outputs("rstw");
        @(negedge clk);
        chk_reset_outputs("rstw2");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
